// File: rtl/mdc_delay_commutator.sv
// mdc_delay_commutator: delay-commutator stage for a multi-path delay
// commutator (MDC) FFT pipeline. The lower channel is delayed by DEPTH
// accepted samples. The upper channel and the delayed lower channel are then
// swapped every DEPTH accepts. The upper output path is delayed by another
// DEPTH accepts. Data passes through unchanged, with no arithmetic.
//
// Parameters
//   WIDTH  bits per real/imaginary component (two's complement)
//   DEPTH  delay length in accepted samples, power of two in 1..256
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   en               sample-accept strobe
//   a_re, a_im       upper input channel
//   b_re, b_im       lower input channel
//   x_re, x_im       upper output channel (registered)
//   y_re, y_im       lower output channel (registered)
//   valid_o          output pair is meaningful (pipeline filled)
module mdc_delay_commutator #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  output logic [WIDTH-1:0] x_re,
  output logic [WIDTH-1:0] x_im,
  output logic [WIDTH-1:0] y_re,
  output logic [WIDTH-1:0] y_im,
  output logic             valid_o
);

  // Complex samples travel as one {re, im} word so the two parts never separate.
  localparam int unsigned CW = 2 * WIDTH;
  localparam int unsigned PW = $clog2(2 * DEPTH);
  localparam int unsigned FW = $clog2(2 * DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(2 * DEPTH);

  logic [PW-1:0] phase;
  logic [FW-1:0] fill;
  logic [CW-1:0] pre_dly  [DEPTH];
  logic [CW-1:0] post_dly [DEPTH];

  logic          sel_c;
  logic [CW-1:0] a_c;
  logic [CW-1:0] db_c;
  logic [CW-1:0] s0_c;
  logic [CW-1:0] s1_c;

  // Phase MSB selects the swap state; it flips every DEPTH accepts.
  assign sel_c = phase[PW-1];
  assign a_c   = {a_re, a_im};
  assign db_c  = pre_dly[DEPTH-1];

  // Commutator.
  always_comb begin
    s0_c = a_c;
    s1_c = db_c;
    if (sel_c) begin
      s0_c = db_c;
      s1_c = a_c;
    end
  end

  // Delay lines, counters and output registers. All of them advance only
  // on accepted samples. Zeroed entries act as the "before fill" content.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      fill    <= '0;
      valid_o <= 1'b0;
      x_re    <= '0;
      x_im    <= '0;
      y_re    <= '0;
      y_im    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pre_dly[i]  <= '0;
        post_dly[i] <= '0;
      end
    end else begin
      // The fill counter has already reached 2*DEPTH when this is accept k >= 2*DEPTH.
      valid_o <= en && (fill == FILL_MAX);
      if (en) begin
        phase <= phase + PW'(1);
        if (fill != FILL_MAX) begin
          fill <= fill + FW'(1);
        end
        pre_dly[0]  <= {b_re, b_im};
        post_dly[0] <= s0_c;
        for (int i = 1; i < int'(DEPTH); i++) begin
          pre_dly[i]  <= pre_dly[i-1];
          post_dly[i] <= post_dly[i-1];
        end
        {x_re, x_im} <= post_dly[DEPTH-1];
        {y_re, y_im} <= s1_c;
      end
    end
  end

endmodule

// File: doc/mdc_delay_commutator.md
MDC_DELAY_COMMUTATOR -- requirements
Module: mdc_delay_commutator

Interface
REQ-001 Parameter WIDTH, default 13: bit width of each real/imaginary sample component, two's complement.
REQ-002 Parameter DEPTH, default 16: delay length in accepted samples; the block SHALL support any power of two from 1 to 256.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  sample-accept strobe; the input pair is accepted on cycles where en=1.
REQ-006 a_re, a_im  input  WIDTH each  upper input channel, complex.
REQ-007 b_re, b_im  input  WIDTH each  lower input channel, complex.
REQ-008 x_re, x_im  output  WIDTH each  upper output channel, registered.
REQ-009 y_re, y_im  output  WIDTH each  lower output channel, registered.
REQ-010 valid_o  output  1  high for one cycle after each accepted sample whose outputs are meaningful.

Function
REQ-011 Index accepted samples k=0,1,2,... from reset; a(k) and b(k) are the inputs on the k-th cycle with en=1.
REQ-012 Internal phase counter, modulo 2*DEPTH, SHALL advance only on accepted samples; sel(k) = floor(k/DEPTH) mod 2, the counter MSB.
REQ-013 Pre-switch delay: dB(k) = b(k-DEPTH), a DEPTH-entry complex delay line that shifts only when en=1.
REQ-014 Commutator: sel=0 -> s0=a(k), s1=dB(k); sel=1 -> s0=dB(k), s1=a(k).
REQ-015 Post-switch delay: x output for sample k = s0(k-DEPTH), a second DEPTH-entry delay line that shifts only when en=1.
REQ-016 y output for sample k = s1(k).
REQ-017 Latency: x/y for sample k SHALL appear on the cycle after the accept cycle of k (one register stage).
REQ-018 Stall: on cycles with en=0, delay lines, phase counter, x and y SHALL hold their values, and valid_o SHALL be 0 on the following cycle.
REQ-019 Fill counter SHALL saturate at 2*DEPTH; valid_o SHALL be 1 after accept k only if k >= 2*DEPTH, otherwise 0.
REQ-020 Before fill, delay-line contents SHALL read as zero, so x/y carry zero-derived data while valid_o=0.
REQ-021 Phase wrap: after k = 2*DEPTH-1 the counter returns to 0 and sel returns to 0 with no dropped or duplicated sample.
REQ-022 DEPTH=1: sel SHALL toggle on every accepted sample and each delay SHALL be exactly one accepted sample.
REQ-023 No arithmetic on data; widths pass through unchanged; real and imaginary parts SHALL always travel together.

Reset
REQ-024 While rst=1 at a rising edge, x_re, x_im, y_re, y_im, valid_o, the phase counter, the fill counter and all delay-line entries SHALL be cleared to 0.
REQ-025 rst SHALL take priority over en; a sample presented with en=1 during reset SHALL be discarded.
REQ-026 Reset mid-stream SHALL restart indexing at k=0; the first valid_o SHALL follow the 2*DEPTH-th accept after reset release.

Verification
REQ-027 DEPTH=4, en=1 continuous, a(k)=k, b(k)=100+k -> valid_o first high after k=8; at k=8 x=100, y=104; at k=12 x=8, y=12.
REQ-028 Same stream with en low on every other cycle -> the x/y/valid_o sequence matches REQ-027 exactly, skipping stalled cycles; outputs hold during stalls.
REQ-029 Imaginary check: a_im(k)=-k, b_im(k)=-(100+k), DEPTH=4 -> at k=8 x_im=-100, y_im=-104; sign is preserved over full WIDTH=13.
REQ-030 Reset asserted at k=10 for 2 cycles, then the stream restarts from k=0 -> all outputs are 0 during reset; valid_o stays 0 until 8 fresh accepts complete.
REQ-031 DEPTH=1, a(k)=k, b(k)=50+k -> first valid after k=2; at k=2 x=50, y=51; at k=3 x=2, y=3.
REQ-032 DEPTH=16, WIDTH=13, 200 random accepts with random en -> outputs match a reference model of REQ-012..REQ-019 on every valid_o cycle.
